// File: rtl/nonce_uart_tx.sv
// Serialises a strobed 32-bit golden nonce as UART 8N1 bytes, LSB byte first.
// Define NONCE_TX_HEADER_EN to prefix every frame with the HEADER byte.
module nonce_uart_tx #(
   parameter int         CLK_HZ = 50_000_000,
   parameter int         BAUD   = 115_200,
   parameter logic [7:0] HEADER = 8'hA5
) (
   input  logic        hash_clk,
   input  logic        reset,
   input  logic        serial_send,
   input  logic [31:0] golden_nonce,
   output logic        serial_busy,
   output logic        txd,
   output logic        overrun
);
   localparam int DIV = CLK_HZ / BAUD;
   localparam int CW  = $clog2(DIV);
`ifdef NONCE_TX_HEADER_EN
   localparam int NBYTES = 5;
`else
   localparam int NBYTES = 4;
`endif
   localparam int IW = $clog2(NBYTES);
   localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic [1:0]          state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [2:0]          bit_q, bit_d;
   logic [IW-1:0]       byte_q, byte_d;
   logic [NBYTES*8-1:0] shift_q, shift_d;
   logic                txd_q, txd_d;
   logic                ovr_q, ovr_d;
   logic [7:0]          cur_byte;
   logic [2:0]          bit_nxt;
   logic                bit_end;

   assign cur_byte    = shift_q[{byte_q, 3'b000} +: 8];
   assign bit_nxt     = bit_q + 3'd1;
   assign bit_end     = (cnt_q == CNT_MAX);
   assign serial_busy = (state_q != S_IDLE) | serial_send;
   assign txd         = txd_q;
   assign overrun     = ovr_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      shift_d = shift_q;
      txd_d   = txd_q;
      ovr_d   = ovr_q | (serial_send & (state_q != S_IDLE));
      case (state_q)
         S_IDLE: begin
            txd_d = 1'b1;
            if (serial_send) begin
`ifdef NONCE_TX_HEADER_EN
               shift_d = {golden_nonce, HEADER};
`else
               shift_d = golden_nonce;
`endif
               byte_d  = '0;
               cnt_d   = '0;
               state_d = S_START;
               txd_d   = 1'b0;
            end
         end
         S_START: begin
            if (bit_end) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = S_DATA;
               txd_d   = cur_byte[0];
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
                  txd_d   = 1'b1;
               end else begin
                  bit_d = bit_nxt;
                  txd_d = cur_byte[bit_nxt];
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            // Next start bit follows the stop bit directly: no idle gap between bytes.
            if (bit_end) begin
               cnt_d = '0;
               if (byte_q == LAST) begin
                  state_d = S_IDLE;
                  txd_d   = 1'b1;
               end else begin
                  byte_d  = byte_q + 1'b1;
                  state_d = S_START;
                  txd_d   = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge hash_clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         shift_q <= '0;
         txd_q   <= 1'b1;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         shift_q <= shift_d;
         txd_q   <= txd_d;
         ovr_q   <= ovr_d;
      end
   end
endmodule

// File: tb/tb_nonce_uart_tx.sv
// Scoreboard bench for nonce_uart_tx: stimulus queues expected bytes, a UART
// receiver process decodes txd and checks each byte and its bit timing.
module tb_nonce_uart_tx;
   localparam int DIV = 10;
`ifdef NONCE_TX_HEADER_EN
   localparam int FRAME_BITS = 50;
`else
   localparam int FRAME_BITS = 40;
`endif

   logic        hash_clk = 1'b0;
   logic        reset = 1'b1;
   logic        serial_send = 1'b0;
   logic [31:0] golden_nonce = '0;
   logic        serial_busy, txd, overrun;

   int checks = 0;
   int failures = 0;
   logic [7:0] exp_q[$];

   nonce_uart_tx #(.CLK_HZ(1000), .BAUD(100), .HEADER(8'hA5)) dut (
      .hash_clk(hash_clk), .reset(reset), .serial_send(serial_send),
      .golden_nonce(golden_nonce), .serial_busy(serial_busy), .txd(txd),
      .overrun(overrun)
   );

   always #5 hash_clk = ~hash_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_word(input logic [31:0] w);
`ifdef NONCE_TX_HEADER_EN
      exp_q.push_back(8'hA5);
`endif
      for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
   endtask

   // Drives a one-cycle strobe; the nonce input is scrambled after the accepting edge.
   task automatic strobe(input logic [31:0] w, input bit accept, input bit sync);
      if (sync) begin
         @(posedge hash_clk); #1;
      end
      golden_nonce = w;
      serial_send  = 1'b1;
      #1 check("busy_on_strobe", {31'd0, serial_busy}, 32'd1);
      if (accept) push_word(w);
      @(posedge hash_clk); #1;
      serial_send  = 1'b0;
      golden_nonce = ~w;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(posedge hash_clk); #1;
         n++;
      end while (serial_busy && n < 2000);
      if (serial_busy) check("wait_idle_timeout", 32'd1, 32'd0);
   endtask

   task automatic pulse_reset(input int cyc);
      @(posedge hash_clk); #1;
      reset = 1'b1;
      repeat (cyc) @(posedge hash_clk);
      #1 reset = 1'b0;
   endtask

   // Receiver: every bit must hold for DIV samples; reset abandons the byte in flight.
   initial begin
      logic [7:0] rx;
      logic       first, bad, abort;
      forever begin
         @(negedge hash_clk);
         if (!reset && txd === 1'b0) begin
            abort = 1'b0; bad = 1'b0; rx = '0; first = 1'b0;
            for (int b = 0; b < 10 && !abort; b++) begin
               for (int s = 0; s < DIV && !abort; s++) begin
                  if (!(b == 0 && s == 0)) @(negedge hash_clk);
                  if (reset) abort = 1'b1;
                  else if (s == 0) first = txd;
                  else if (txd !== first) bad = 1'b1;
               end
               if (b >= 1 && b <= 8) rx[b-1] = first;
               if ((b == 0 && first !== 1'b0) || (b == 9 && first !== 1'b1)) bad = 1'b1;
            end
            if (!abort) begin
               if (exp_q.size() == 0) check("rx_unexpected_byte", {23'd0, bad, rx}, 32'hFFFF);
               else check("rx_byte", {23'd0, bad, rx}, {24'd0, exp_q.pop_front()});
            end
         end
      end
   end

   initial begin
      int n, bad;
      repeat (3) @(posedge hash_clk);
      #1 reset = 1'b0;

      // Idle after reset.
      bad = 0;
      repeat (100) begin
         @(negedge hash_clk);
         if (txd !== 1'b1 || serial_busy !== 1'b0 || overrun !== 1'b0) bad++;
      end
      check("idle_after_reset", bad, 0);

      // Single frame with busy-length measurement.
      strobe(32'h12345678, 1'b1, 1'b1);
      n = 0;
      do begin
         @(negedge hash_clk);
         if (serial_busy) n++;
      end while (serial_busy && n < 2000);
      check("busy_cycles", n, FRAME_BITS * DIV);
      wait_idle();
      check("queue_empty_1", exp_q.size(), 0);
      check("overrun_clear_1", {31'd0, overrun}, 32'd0);

      // Overrun: second strobe mid-frame is dropped and overrun sticks.
      strobe(32'hCAFEF00D, 1'b1, 1'b1);
      repeat (49) @(posedge hash_clk);
      strobe(32'hDEADBEEF, 1'b0, 1'b1);
      @(negedge hash_clk);
      check("overrun_set", {31'd0, overrun}, 32'd1);
      wait_idle();
      repeat (30) @(posedge hash_clk);
      check("overrun_held", {31'd0, overrun}, 32'd1);
      check("queue_empty_2", exp_q.size(), 0);
      pulse_reset(2);
      @(negedge hash_clk);
      check("overrun_cleared_by_reset", {31'd0, overrun}, 32'd0);

      // Back-to-back: second strobe on the first idle cycle.
      strobe(32'hA1B2C3D4, 1'b1, 1'b1);
      wait_idle();
      strobe(32'h55AA0FF0, 1'b1, 1'b0);
      wait_idle();
      repeat (2) @(posedge hash_clk);
      check("queue_empty_b2b", exp_q.size(), 0);
      check("overrun_b2b", {31'd0, overrun}, 32'd0);

      // Reset 120 cycles into a frame: only byte 0 completes.
      strobe(32'h12345678, 1'b0, 1'b1);
`ifdef NONCE_TX_HEADER_EN
      exp_q.push_back(8'hA5);
`else
      exp_q.push_back(8'h78);
`endif
      repeat (119) @(posedge hash_clk);
      #1 reset = 1'b1;
      @(posedge hash_clk); #1;
      check("abort_txd", {31'd0, txd}, 32'd1);
      reset = 1'b0;
      check("abort_busy", {31'd0, serial_busy}, 32'd0);
      check("queue_empty_abort", exp_q.size(), 0);
      strobe(32'h0F1E2D3C, 1'b1, 1'b1);
      wait_idle();
      repeat (2) @(posedge hash_clk);
      check("queue_empty_after_abort", exp_q.size(), 0);

      // Strobe coincident with reset is ignored.
      @(posedge hash_clk); #1;
      reset = 1'b1; serial_send = 1'b1; golden_nonce = 32'h87654321;
      @(posedge hash_clk); #1;
      reset = 1'b0; serial_send = 1'b0;
      bad = 0;
      repeat (20) begin
         @(negedge hash_clk);
         if (txd !== 1'b1 || serial_busy !== 1'b0) bad++;
      end
      check("send_during_reset_ignored", bad, 0);

      // Small-value word (header frame when enabled).
      strobe(32'h00000001, 1'b1, 1'b1);
      n = 0;
      do begin
         @(negedge hash_clk);
         if (serial_busy) n++;
      end while (serial_busy && n < 2000);
      check("busy_cycles_2", n, FRAME_BITS * DIV);
      wait_idle();
      repeat (2) @(posedge hash_clk);
      check("queue_empty_final", exp_q.size(), 0);
      check("overrun_final", {31'd0, overrun}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
